// File: rtl/queue_enq_arbiter.sv
// Round-robin arbiter that lets NREQ producers share one queue write port,
// granting each winner a burst of up to MAX_BURST words before rotating.
module queue_enq_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_enqueue,
    output logic [WIDTH-1:0]          fifo_data_in,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [15:0]               xfer_count
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last;
    logic [7:0]      burst_cnt;

    logic            owner_valid;
    logic            transfer;
    logic            burst_done;
    logic            pick_found;
    logic [OW-1:0]   pick_idx;

    // Reset wins over a same-cycle transfer, so the handshake is masked by rst.
    assign owner_valid = req_valid[owner];
    assign transfer    = !rst && (state == GRANT) && owner_valid && !fifo_full;
    assign burst_done  = (burst_cnt == 8'(MAX_BURST - 1));

    // Rotating priority: the requester just after the previous owner goes first.
    always_comb begin
        logic [OW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = OW'((int'(last) + 1 + k) % NREQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign fifo_enqueue = transfer;
    assign fifo_data_in = (state == GRANT) ? req_data[int'(owner)*WIDTH +: WIDTH] : '0;
    assign grant_id     = owner;
    assign busy         = (state == GRANT);

    // A full queue simply withholds the transfer, which freezes every register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last       <= OW'(NREQ - 1);
            burst_cnt  <= '0;
            xfer_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_valid) begin
                        last  <= owner;
                        state <= IDLE;
                    end else if (transfer) begin
                        burst_cnt  <= burst_cnt + 8'd1;
                        xfer_count <= xfer_count + 16'd1;
                        if (burst_done) begin
                            last  <= owner;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed bench for queue_enq_arbiter: burst, rotation, stall, release and reset
// scenarios on one instance, counter wrap on a long-burst second instance.
module tb_queue_enq_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_enqueue;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] xfer_count;

    logic        w_rst;
    logic [3:0]  w_ready;
    logic        w_enqueue;
    logic [7:0]  w_data_in;
    logic [1:0]  w_grant;
    logic        w_busy;
    logic [15:0] w_xfer;

    int checks = 0;
    int errors = 0;

    queue_enq_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_enqueue (fifo_enqueue),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy),
        .xfer_count   (xfer_count)
    );

    // Long bursts let the wrap instance reach 16'hFFFF in the fewest cycles.
    queue_enq_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(255)) u_wrap (
        .clk          (clk),
        .rst          (w_rst),
        .req_valid    (4'b0001),
        .req_data     (32'h0000_0077),
        .req_ready    (w_ready),
        .fifo_full    (1'b0),
        .fifo_enqueue (w_enqueue),
        .fifo_data_in (w_data_in),
        .grant_id     (w_grant),
        .busy         (w_busy),
        .xfer_count   (w_xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic full);
        req_valid = valid;
        fifo_full = full;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        w_rst     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0055;
        fifo_full = 1'b0;
        tick();
        tick();
        w_rst = 1'b0;
        rst   = 1'b0;
        #1;

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_enq", fifo_enqueue, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_data", fifo_data_in, 0);
        checkOutput("rst_xfer", xfer_count, 0);

        // Single requester: one burst, idle gap, regrant to itself.
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_idle_enq", fifo_enqueue, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("t1_busy", busy, 1);
            checkOutput("t1_enq", fifo_enqueue, 1);
            checkOutput("t1_ready", req_ready, 4'b0001);
            checkOutput("t1_data", fifo_data_in, 8'h55);
            checkOutput("t1_xfer", xfer_count, k);
            tick();
        end
        checkOutput("t1_gap_busy", busy, 0);
        checkOutput("t1_gap_enq", fifo_enqueue, 0);
        checkOutput("t1_xfer4", xfer_count, 4);
        tick();
        checkOutput("t1_regrant_busy", busy, 1);
        checkOutput("t1_regrant_id", grant_id, 0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t1_release_enq", fifo_enqueue, 0);
        tick();
        checkOutput("t1_release_busy", busy, 0);
        checkOutput("t1_release_xfer", xfer_count, 4);

        // Full contention after reset: strict 0,1,2,3 rotation, 4 words each.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_data = 32'hD3C2_B1A0;
        applyStimulus(4'b1111, 1'b0);
        for (int g = 0; g < 4; g++) begin
            checkOutput("t2_gap_busy", busy, 0);
            checkOutput("t2_gap_enq", fifo_enqueue, 0);
            tick();
            for (int k = 0; k < 4; k++) begin
                checkOutput("t2_grant", grant_id, g);
                checkOutput("t2_ready", req_ready, 4'b0001 << g);
                checkOutput("t2_data", fifo_data_in, 8'hA0 + 8'h11 * g);
                checkOutput("t2_enq", fifo_enqueue, 1);
                tick();
            end
        end
        checkOutput("t2_final_gap", busy, 0);
        checkOutput("t2_xfer16", xfer_count, 16);
        tick();
        checkOutput("t2_wrap_grant", grant_id, 0);
        checkOutput("t2_wrap_busy", busy, 1);
        applyStimulus(4'b0000, 1'b0);
        tick();

        // Three-cycle queue-full stall in the middle of requester 2's burst.
        applyStimulus(4'b0100, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checkOutput("t3_pre_enq", fifo_enqueue, 1);
            checkOutput("t3_pre_data", fifo_data_in, 8'hC2);
            tick();
        end
        applyStimulus(4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t3_stall_enq", fifo_enqueue, 0);
            checkOutput("t3_stall_ready", req_ready, 0);
            checkOutput("t3_stall_grant", grant_id, 2);
            checkOutput("t3_stall_busy", busy, 1);
            tick();
        end
        applyStimulus(4'b0100, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checkOutput("t3_post_enq", fifo_enqueue, 1);
            checkOutput("t3_post_ready", req_ready, 4'b0100);
            tick();
        end
        checkOutput("t3_done_busy", busy, 0);
        checkOutput("t3_xfer", xfer_count, 20);
        applyStimulus(4'b0000, 1'b0);
        tick();

        // Owner 1 releases after two words while requester 3 waits.
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("t4_grant1", grant_id, 1);
        applyStimulus(4'b1010, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checkOutput("t4_ready", req_ready, 4'b0010);
            checkOutput("t4_enq", fifo_enqueue, 1);
            tick();
        end
        applyStimulus(4'b1000, 1'b0);
        checkOutput("t4_drop_enq", fifo_enqueue, 0);
        checkOutput("t4_drop_ready", req_ready, 0);
        tick();
        checkOutput("t4_idle_busy", busy, 0);
        tick();
        checkOutput("t4_grant3", grant_id, 3);
        checkOutput("t4_busy3", busy, 1);
        checkOutput("t4_xfer", xfer_count, 22);

        // Reset in the middle of requester 2's burst.
        applyStimulus(4'b0000, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("t5_grant2", grant_id, 2);
        tick();
        checkOutput("t5_xfer23", xfer_count, 23);
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        checkOutput("t5_rst_enq", fifo_enqueue, 0);
        checkOutput("t5_rst_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_xfer", xfer_count, 0);
        tick();
        checkOutput("t5_grant0", grant_id, 0);
        checkOutput("t5_busy_after", busy, 1);
        applyStimulus(4'b0000, 1'b0);

        // Transfer counter wrap on the long-burst instance.
        for (int i = 0; i < 70000 && w_xfer != 16'hFFFF; i++) tick();
        checkOutput("wrap_ffff", w_xfer, 16'hFFFF);
        for (int i = 0; i < 300 && !w_enqueue; i++) tick();
        checkOutput("wrap_enq", w_enqueue, 1);
        tick();
        checkOutput("wrap_zero", w_xfer, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
